load_store_unit: RTL and testbench

- Sits between the execute stage and the word-organised data memory.
- Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into full-word memory accesses only.
- Handles byte/halfword extraction, sign/zero extension, read-modify-write for sub-word stores, and splitting of misaligned accesses that cross a word boundary into two word accesses.
- Core side uses valid/ready request and response handshakes.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_lane_merge.sv | 55 +++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I access encodings, FSM states
// and access-size decode.
package lsu_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ0  = 3'd1,
        ST_READ1  = 3'd2,
        ST_WRITE0 = 3'd3,
        ST_WRITE1 = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    // Access size in bytes; only meaningful for legal funct3 values.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 > STORE_SW);
        case (funct3)
            LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: return 1'b0;
            default:                                        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane logic: merges store bytes into a two-word window and
// extracts/extends load data from the same window.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_buf0,
    input  logic [31:0] i_buf1,
    output logic [31:0] o_merged0,
    output logic [31:0] o_merged1,
    output logic [31:0] o_load_data
);

    logic [63:0] w_pair;
    logic [63:0] w_mask;
    logic [63:0] w_data;
    logic [63:0] w_merged;
    logic [31:0] w_window;
    logic [7:0]  w_lane_en;

    assign w_pair = {i_buf1, i_buf0};

    // Lane gi of the little-endian {buf1,buf0} window takes store data when it
    // falls inside [off, off+size).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign w_lane_en[gi] = (4'(gi) >= {2'b00, i_off}) &&
                                   (4'(gi) < ({2'b00, i_off} + {1'b0, i_size}));
            assign w_mask[8*gi +: 8] = {8{w_lane_en[gi]}};
        end
    endgenerate

    assign w_data    = {32'b0, i_wdata} << {i_off, 3'b000};
    assign w_merged  = (w_pair & ~w_mask) | (w_data & w_mask);
    assign o_merged0 = w_merged[31:0];
    assign o_merged1 = w_merged[63:32];

    assign w_window = 32'(w_pair >> {i_off, 3'b000});

    always_comb begin
        o_load_data = w_window;
        case (i_funct3)
            LOAD_LB:  o_load_data = {{24{w_window[7]}}, w_window[7:0]};
            LOAD_LH:  o_load_data = {{16{w_window[15]}}, w_window[15:0]};
            LOAD_LBU: o_load_data = {24'b0, w_window[7:0]};
            LOAD_LHU: o_load_data = {16'b0, w_window[15:0]};
            default:  o_load_data = w_window;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-only data memory:
// read-modify-write for sub-word stores and two-word split for misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_misaligned,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_is_store,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_type,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf0;
    logic [31:0]       r_buf1;
    logic              r_err;
    logic              r_span;

    logic [2:0]        w_req_size;
    logic [1:0]        w_req_off;
    logic              w_req_span;
    logic              w_req_illegal;
    logic              w_req_aligned_sw;
    logic [MEM_AW-1:0] w_word0;
    logic [MEM_AW-1:0] w_word1;
    logic [31:0]       w_merged0;
    logic [31:0]       w_merged1;
    logic [31:0]       w_load_data;

    assign w_req_size       = access_size(req_funct3);
    assign w_req_off        = req_addr[1:0];
    assign w_req_span       = ((w_req_size == 3'd2) && (w_req_off == 2'd3)) ||
                              ((w_req_size == 3'd4) && (w_req_off != 2'd0));
    assign w_req_illegal    = funct3_illegal(req_is_store, req_funct3);
    assign w_req_aligned_sw = req_is_store && (req_funct3 == STORE_SW) && (w_req_off == 2'd0);

    // Second word wraps naturally at the top of the word address space.
    assign w_word0 = r_addr[ADDR_W-1:2];
    assign w_word1 = w_word0 + MEM_AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_wdata    <= '0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_err      <= 1'b0;
            r_span     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_funct3   <= req_funct3;
                        r_is_store <= req_is_store;
                        r_wdata    <= req_wdata;
                        r_err      <= w_req_illegal;
                        r_span     <= w_req_span && !w_req_illegal;
                        if (w_req_illegal)
                            r_state <= ST_RESP;
                        else if (w_req_aligned_sw)
                            r_state <= ST_WRITE0;
                        else
                            r_state <= ST_READ0;
                    end
                end
                ST_READ0: begin
                    r_buf0 <= mem_rdata;
                    if (r_span)
                        r_state <= ST_READ1;
                    else
                        r_state <= r_is_store ? ST_WRITE0 : ST_RESP;
                end
                ST_READ1: begin
                    r_buf1  <= mem_rdata;
                    r_state <= r_is_store ? ST_WRITE0 : ST_RESP;
                end
                ST_WRITE0: r_state <= r_span ? ST_WRITE1 : ST_RESP;
                ST_WRITE1: r_state <= ST_RESP;
                ST_RESP:   if (resp_ready) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // An aligned SW never reads, but its full-width lane mask makes the stale
    // buffer contents irrelevant.
    lsu_lane_merge u_lane_merge (
        .i_off       (r_addr[1:0]),
        .i_size      (access_size(r_funct3)),
        .i_funct3    (r_funct3),
        .i_wdata     (r_wdata),
        .i_buf0      (r_buf0),
        .i_buf1      (r_buf1),
        .o_merged0   (w_merged0),
        .o_merged1   (w_merged1),
        .o_load_data (w_load_data)
    );

    assign req_ready       = (r_state == ST_IDLE) && !rst;
    assign resp_valid      = (r_state == ST_RESP);
    assign resp_rdata      = (resp_valid && !r_is_store && !r_err) ? w_load_data : 32'b0;
    assign resp_err        = resp_valid && r_err;
    assign resp_misaligned = resp_valid && r_span;
    assign mem_type        = STORE_SW;
    assign mem_is_store    = ((r_state == ST_WRITE0) || (r_state == ST_WRITE1)) && !rst;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_READ0:  mem_addr = w_word0;
            ST_READ1:  mem_addr = w_word1;
            ST_WRITE0: begin
                mem_addr  = w_word0;
                mem_wdata = w_merged0;
            end
            ST_WRITE1: begin
                mem_addr  = w_word1;
                mem_wdata = w_merged1;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed test-plan cases plus random traffic,
// checked against a byte-addressed reference memory.
module tb_load_store_unit;

    localparam int ADDR_W = 16;
    localparam int MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_is_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              resp_misaligned;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_is_store;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_type;
    logic [31:0]       mem_rdata;

    logic [31:0]       mem     [0:(1<<MEM_AW)-1];
    logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    logic [MEM_AW-1:0] pulse_addr [$];
    logic [31:0] last_rdata;

    load_store_unit #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .resp_misaligned (resp_misaligned),
        .mem_addr        (mem_addr),
        .mem_is_store    (mem_is_store),
        .mem_wdata       (mem_wdata),
        .mem_type        (mem_type),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the falling edge.
    assign mem_rdata = mem[mem_addr];
    always @(negedge clk) begin
        if (mem_is_store) begin
            mem[mem_addr] = mem_wdata;
            n_pulses = n_pulses + 1;
            pulse_addr.push_back(mem_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke_word(input logic [MEM_AW-1:0] w, input logic [31:0] val);
        mem[w] = val;
        for (int i = 0; i < 4; i++) ref_mem[{w, 2'(i)}] = val[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [MEM_AW-1:0] w);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[{w, 2'(i)}];
        return v;
    endfunction

    task automatic do_txn(input logic is_store, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input int hold);
        int size, off, lat, exp_lat, exp_pulses, w;
        bit illegal, span;
        logic [31:0] exp_rdata, held_rdata;
        logic [ADDR_W-1:0] a;
        logic [MEM_AW-1:0] w0, w1;

        size    = 1 << f3[1:0];
        off     = int'(addr[1:0]);
        illegal = is_store ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        span    = !illegal && (off + size > 4);
        w0      = addr[ADDR_W-1:2];
        w1      = w0 + 1'b1;

        exp_rdata = 32'b0;
        if (!illegal && !is_store) begin
            for (int i = 0; i < size; i++) begin
                a = addr + ADDR_W'(i);
                exp_rdata = exp_rdata | (32'(ref_mem[a]) << (8*i));
            end
            if (!f3[2] && size < 4 && exp_rdata[8*size-1])
                exp_rdata = exp_rdata | (32'hFFFF_FFFF << (8*size));
        end
        if (illegal)        exp_lat = 1;
        else if (!is_store) exp_lat = span ? 3 : 2;
        else if (size == 4 && off == 0) exp_lat = 2;
        else                exp_lat = span ? 5 : 3;
        exp_pulses = (is_store && !illegal) ? (span ? 2 : 1) : 0;

        n_pulses = 0;
        pulse_addr.delete();
        @(negedge clk);
        req_valid = 1'b1; req_is_store = is_store; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) check_eq("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end

        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rdata", resp_rdata, exp_rdata);
        check_eq("err", 32'(resp_err), 32'(illegal));
        check_eq("misaligned", 32'(resp_misaligned), 32'(span));
        check_eq("write_pulses", 32'(n_pulses), 32'(exp_pulses));
        if (exp_pulses >= 1 && pulse_addr.size() >= 1) check_eq("waddr0", 32'(pulse_addr[0]), 32'(w0));
        if (exp_pulses == 2 && pulse_addr.size() >= 2) check_eq("waddr1", 32'(pulse_addr[1]), 32'(w1));
        last_rdata = resp_rdata;

        if (is_store && !illegal) begin
            for (int i = 0; i < size; i++) begin
                a = addr + ADDR_W'(i);
                ref_mem[a] = wdata[8*i +: 8];
            end
            check_eq("mem_word0", mem[w0], ref_word(w0));
            if (span) check_eq("mem_word1", mem[w1], ref_word(w1));
        end

        held_rdata = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_rdata", resp_rdata, held_rdata);
            check_eq("hold_err", 32'(resp_err), 32'(illegal));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq("post_hs_req_ready", 32'(req_ready), 32'd1);
        check_eq("post_hs_resp_valid", 32'(resp_valid), 32'd0);
        $display("txn %s f3=%0d addr=0x%04h wdata=0x%08h -> rdata=0x%08h err=%0b mis=%0b lat=%0d",
                 is_store ? "ST" : "LD", f3, addr, wdata, held_rdata, illegal, span, lat);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [31:0] keep0, keep1;
        for (int i = 0; i < (1 << MEM_AW); i++) poke_word(MEM_AW'(i), $urandom);

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_mem_is_store", 32'(mem_is_store), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("mem_type", 32'(mem_type), 32'd2);
        rst = 1'b0;
        #1;
        check_eq("idle_req_ready", 32'(req_ready), 32'd1);

        // Test-plan cases
        poke_word(14'h0010, 32'h8877_6655);
        poke_word(14'h0011, 32'hDDCC_BBAA);
        do_txn(1'b0, 3'b000, 16'h0043, 32'h0, 0);
        check_eq("tp_lb", last_rdata, 32'hFFFF_FF88);
        do_txn(1'b0, 3'b100, 16'h0043, 32'h0, 0);
        check_eq("tp_lbu", last_rdata, 32'h0000_0088);
        do_txn(1'b0, 3'b001, 16'h0042, 32'h0, 0);
        check_eq("tp_lh", last_rdata, 32'hFFFF_8877);
        do_txn(1'b1, 3'b000, 16'h0041, 32'h0000_00AB, 0);
        check_eq("tp_sb_word", mem[14'h0010], 32'h8877_AB55);
        do_txn(1'b0, 3'b010, 16'h0042, 32'h0, 0);
        check_eq("tp_lw_mis", last_rdata, 32'hBBAA_8877);
        poke_word(14'h3FFF, 32'h0102_0304);
        poke_word(14'h0000, 32'hA5A5_A5A5);
        do_txn(1'b1, 3'b010, 16'hFFFF, 32'h1122_3344, 0);
        check_eq("tp_sw_wrap_hi", mem[14'h3FFF], 32'h4402_0304);
        check_eq("tp_sw_wrap_lo", mem[14'h0000], 32'hA511_2233);
        do_txn(1'b0, 3'b010, 16'h0040, 32'h0, 3);
        do_txn(1'b0, 3'b011, 16'h0040, 32'h0, 1);
        do_txn(1'b1, 3'b011, 16'h0041, 32'h1234_5678, 0);

        // Reset while a misaligned SW is in READ1: nothing may be written.
        keep0 = mem[14'h0020];
        keep1 = mem[14'h0021];
        n_pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 16'h0081; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rstmid_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("rstmid_req_ready_after", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rstmid_pulses", 32'(n_pulses), 32'd0);
        check_eq("rstmid_word0", mem[14'h0020], keep0);
        check_eq("rstmid_word1", mem[14'h0021], keep1);

        // Random traffic concentrated near the bottom and the wrap point.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) ra = 16'hFFF0 | 16'($urandom_range(0, 15));
            else                           ra = 16'($urandom_range(0, 255));
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                   $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
